// File: rtl/osc_meas_pkg.sv
// rtl/osc_meas_pkg.sv - shared types, default widths and saturating increment for the oscillator frequency meter
package osc_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        HOLD = 2'd2
    } meas_state_t;

    localparam int GATE_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    // Working width of the saturating helper; counters up to 32 bits are supported.
    localparam int SAT_W = 32;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                 input logic [SAT_W-1:0] max_val);
        return (val >= max_val) ? max_val : val + 1'b1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser followed by a rising-edge detector
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    // Shift the asynchronous input through the synchroniser, then keep one delayed copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise_edge = r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/osc_freq_meter.sv
// rtl/osc_freq_meter.sv - gated rising-edge counter for ring oscillators; OSC_FREQ_DIFF_EN adds a reference channel and signed difference
module osc_freq_meter
    import osc_meas_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int GATE_W      = GATE_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    osc_in,
`ifdef OSC_FREQ_DIFF_EN
    input  logic                    osc_ref_in,
`endif
    input  logic                    start,
    input  logic                    cont,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CNT_W-1:0]        result,
    output logic                    overflow
`ifdef OSC_FREQ_DIFF_EN
    ,
    output logic signed [CNT_W:0]   diff
`endif
);

    localparam logic [GATE_W-1:0] TIMER_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    meas_state_t        r_state;
    logic [GATE_W-1:0]  r_timer;
    logic               r_busy;
    logic               r_res_valid;
    logic [CNT_W-1:0]   r_result;
    logic               r_overflow;

    logic [CNT_W-1:0]   r_cnt_a;
    logic               r_sat_a;
    logic               w_edge_a;
    logic [CNT_W-1:0]   w_cnt_a_next;
    logic               w_sat_a_next;

    logic               w_last;
    logic               w_accept;
    logic               w_ovf_any;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_a (
        .clk       (clk),
        .rst       (rst),
        .async_in  (osc_in),
        .rise_edge (w_edge_a)
    );

    // An edge arriving on a saturated counter marks the window as overflowed.
    assign w_cnt_a_next = w_edge_a ? CNT_W'(sat_inc(SAT_W'(r_cnt_a), SAT_W'(CNT_MAX))) : r_cnt_a;
    assign w_sat_a_next = r_sat_a | (w_edge_a & (r_cnt_a == CNT_MAX));

`ifdef OSC_FREQ_DIFF_EN
    logic [CNT_W-1:0]   r_cnt_b;
    logic               r_sat_b;
    logic               w_edge_b;
    logic [CNT_W-1:0]   w_cnt_b_next;
    logic               w_sat_b_next;
    logic signed [CNT_W:0] w_diff_next;
    logic signed [CNT_W:0] r_diff;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_b (
        .clk       (clk),
        .rst       (rst),
        .async_in  (osc_ref_in),
        .rise_edge (w_edge_b)
    );

    assign w_cnt_b_next = w_edge_b ? CNT_W'(sat_inc(SAT_W'(r_cnt_b), SAT_W'(CNT_MAX))) : r_cnt_b;
    assign w_sat_b_next = r_sat_b | (w_edge_b & (r_cnt_b == CNT_MAX));
    assign w_diff_next  = $signed({1'b0, w_cnt_a_next}) - $signed({1'b0, w_cnt_b_next});
    assign w_ovf_any    = w_sat_a_next | w_sat_b_next;
    assign diff         = r_diff;

    // Reference channel counts over exactly the same window as the main channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_b <= '0;
            r_sat_b <= 1'b0;
            r_diff  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start || cont) begin
                        r_cnt_b <= '0;
                        r_sat_b <= 1'b0;
                    end
                end
                GATE: begin
                    r_cnt_b <= w_cnt_b_next;
                    r_sat_b <= w_sat_b_next;
                    if (w_last) begin
                        r_diff <= w_diff_next;
                    end
                end
                HOLD: begin
                    if (w_accept && cont) begin
                        r_cnt_b <= '0;
                        r_sat_b <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    assign w_ovf_any = w_sat_a_next;
`endif

    assign w_last   = (r_timer == TIMER_LAST);
    assign w_accept = r_res_valid & res_ready;

    assign busy      = r_busy;
    assign res_valid = r_res_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;

    // Measurement sequencer: arm, count for the gate window, then hold the result until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_cnt_a     <= '0;
            r_sat_a     <= 1'b0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start || cont) begin
                        r_state <= GATE;
                        r_timer <= '0;
                        r_cnt_a <= '0;
                        r_sat_a <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                GATE: begin
                    r_cnt_a <= w_cnt_a_next;
                    r_sat_a <= w_sat_a_next;
                    if (w_last) begin
                        // The final gate cycle's edge is included in the loaded result.
                        r_state     <= HOLD;
                        r_busy      <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_result    <= w_cnt_a_next;
                        r_overflow  <= w_ovf_any;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_res_valid <= 1'b0;
                        if (cont) begin
                            r_state <= GATE;
                            r_timer <= '0;
                            r_cnt_a <= '0;
                            r_sat_a <= 1'b0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
